// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that uses one dual-port SRAM as a circular word buffer.
// Port A carries writes only. Port B carries prefetch reads into a 2-entry output buffer,
// which lets the read port run at one word per cycle.
// Optional feature: define SRAM_FIFO_AFULL_EN to add the AFULL_THRESH parameter and a
// registered afull_out flag.
module sram_fifo_ctrl #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 15
`ifdef SRAM_FIFO_AFULL_EN
  ,
  parameter int unsigned AFULL_THRESH = (2 ** AWIDTH) - 16
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  input  logic [DWIDTH-1:0] wr_data_in,
  output logic              rd_valid_out,
  input  logic              rd_ready_in,
  output logic [DWIDTH-1:0] rd_data_out,
  output logic [AWIDTH+1:0] count_out,
  output logic              sram_en_a_out,
  output logic              sram_we_a_out,
  output logic [AWIDTH-1:0] sram_addr_a_out,
  output logic [DWIDTH-1:0] sram_d_a_out,
  output logic              sram_en_b_out,
  output logic              sram_we_b_out,
  output logic [AWIDTH-1:0] sram_addr_b_out,
  input  logic [DWIDTH-1:0] sram_q_b_in
`ifdef SRAM_FIFO_AFULL_EN
  ,
  output logic              afull_out
`endif
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] SramFull = (AWIDTH + 1)'(DEPTH);

  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   sram_cnt_q, sram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DWIDTH-1:0] out_mem_q [2];
  logic              out_head_q, out_head_d;
  logic [1:0]        out_cnt_q, out_cnt_d;

  logic       accept, issue, pop;
  logic [1:0] out_level;

  // Handshakes and the prefetch decision.
  // out_level counts output slots already claimed after this cycle's pop.
  always_comb begin
    wr_ready_out = !rst_in && (sram_cnt_q < SramFull);
    accept       = wr_valid_in && wr_ready_out;
    rd_valid_out = (out_cnt_q != 2'd0);
    pop          = rd_valid_out && rd_ready_in;
    out_level    = out_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    issue        = !rst_in && (sram_cnt_q != '0) && (out_level < 2'd2);
  end

  // SRAM port drive, head-of-FIFO data and occupancy.
  always_comb begin
    sram_en_a_out   = accept;
    sram_we_a_out   = accept;
    sram_addr_a_out = accept ? wptr_q : '0;
    sram_d_a_out    = accept ? wr_data_in : '0;
    sram_en_b_out   = issue;
    sram_we_b_out   = 1'b0;
    sram_addr_b_out = issue ? rptr_q : '0;
    rd_data_out     = out_mem_q[out_head_q];
    count_out       = {1'b0, sram_cnt_q} + (AWIDTH + 2)'(inflight_q)
                    + (AWIDTH + 2)'(out_cnt_q);
  end

  // Next-state for the pointers and counters. Pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    sram_cnt_d = sram_cnt_q;
    if (accept) wptr_d = wptr_q + 1'b1;
    if (issue)  rptr_d = rptr_q + 1'b1;
    case ({accept, issue})
      2'b10:   sram_cnt_d = sram_cnt_q + 1'b1;
      2'b01:   sram_cnt_d = sram_cnt_q - 1'b1;
      default: sram_cnt_d = sram_cnt_q;
    endcase
    inflight_d = issue;
    out_cnt_d  = out_level;
    out_head_d = out_head_q ^ pop;
  end

  // State registers. Read data returning one cycle after an issue goes into the buffer tail.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      sram_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      out_head_q   <= 1'b0;
      out_cnt_q    <= 2'd0;
      out_mem_q[0] <= '0;
      out_mem_q[1] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      out_head_q <= out_head_d;
      out_cnt_q  <= out_cnt_d;
      if (inflight_q) out_mem_q[out_head_q ^ out_cnt_q[0]] <= sram_q_b_in;
    end
  end

`ifdef SRAM_FIFO_AFULL_EN
  localparam logic [AWIDTH+1:0] AfullLvl = (AWIDTH + 2)'(AFULL_THRESH);

  logic afull_q;

  // Registered almost-full flag for early upstream back-pressure.
  always_ff @(posedge clk_in) begin
    if (rst_in) afull_q <= 1'b0;
    else        afull_q <= (count_out >= AfullLvl);
  end

  assign afull_out = afull_q;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl, with a small behavioural dual-port SRAM model.
// Inputs change 1 time unit after posedge, and outputs are sampled on negedge.
module tb_sram_fifo_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            wr_valid_in, wr_ready_out;
  logic [DW-1:0]   wr_data_in;
  logic            rd_valid_out, rd_ready_in;
  logic [DW-1:0]   rd_data_out;
  logic [AW+1:0]   count_out;
  logic            sram_en_a_out, sram_we_a_out, sram_en_b_out, sram_we_b_out;
  logic [AW-1:0]   sram_addr_a_out, sram_addr_b_out;
  logic [DW-1:0]   sram_d_a_out;
  logic [DW-1:0]   sram_q_b_in = '0;
`ifdef SRAM_FIFO_AFULL_EN
  logic            afull_out;
`endif

  always #5 clk_in = ~clk_in;

  sram_fifo_ctrl #(
    .DWIDTH(DW),
    .AWIDTH(AW)
`ifdef SRAM_FIFO_AFULL_EN
    ,
    .AFULL_THRESH(8)
`endif
  ) dut (
`ifdef SRAM_FIFO_AFULL_EN
    .afull_out      (afull_out),
`endif
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .wr_valid_in    (wr_valid_in),
    .wr_ready_out   (wr_ready_out),
    .wr_data_in     (wr_data_in),
    .rd_valid_out   (rd_valid_out),
    .rd_ready_in    (rd_ready_in),
    .rd_data_out    (rd_data_out),
    .count_out      (count_out),
    .sram_en_a_out  (sram_en_a_out),
    .sram_we_a_out  (sram_we_a_out),
    .sram_addr_a_out(sram_addr_a_out),
    .sram_d_a_out   (sram_d_a_out),
    .sram_en_b_out  (sram_en_b_out),
    .sram_we_b_out  (sram_we_b_out),
    .sram_addr_b_out(sram_addr_b_out),
    .sram_q_b_in    (sram_q_b_in)
  );

  // Behavioural dual_sram: port A writes, port B reads with registered output.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk_in) begin
    if (sram_en_a_out && sram_we_a_out) mem[sram_addr_a_out] <= sram_d_a_out;
    if (sram_en_b_out) sram_q_b_in <= mem[sram_addr_b_out];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in      = 1'b1;
    wr_valid_in = 1'b0;
    rd_ready_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  int            sent, recv;
  logic [DW-1:0] sb [$];
  logic          held_v;
  logic [DW-1:0] held_d;

  initial begin
    rst_in      = 1'b1;
    wr_valid_in = 1'b0;
    wr_data_in  = '0;
    rd_ready_in = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk_in);
    check("rst_wr_ready", wr_ready_out, 0);
    check("rst_count", count_out, 0);
    check("rst_rd_valid", rd_valid_out, 0);
    check("rst_rd_data", rd_data_out, 0);
    check("rst_en_a", sram_en_a_out, 0);
    check("rst_en_b", sram_en_b_out, 0);
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("idle_wr_ready", wr_ready_out, 1);

    // Single word latency
    tick();
    wr_valid_in = 1'b1;
    wr_data_in  = 32'hA5A5_0001;
    @(negedge clk_in);
    check("w1_en_a", sram_en_a_out, 1);
    check("w1_we_a", sram_we_a_out, 1);
    check("w1_addr_a", sram_addr_a_out, 0);
    check("w1_d_a", sram_d_a_out, 32'hA5A5_0001);
    tick();
    wr_valid_in = 1'b0;
    @(negedge clk_in);
    check("w1_en_b", sram_en_b_out, 1);
    check("w1_addr_b", sram_addr_b_out, 0);
    check("w1_count_n1", count_out, 1);
    check("w1_valid_n1", rd_valid_out, 0);
    tick();
    @(negedge clk_in);
    check("w1_en_b_n2", sram_en_b_out, 0);
    check("w1_valid_n2", rd_valid_out, 0);
    check("w1_count_n2", count_out, 1);
    tick();
    @(negedge clk_in);
    check("w1_valid_n3", rd_valid_out, 1);
    check("w1_data_n3", rd_data_out, 32'hA5A5_0001);
    check("w1_count_n3", count_out, 1);
    tick();
    @(negedge clk_in);
    check("w1_hold_valid", rd_valid_out, 1);
    check("w1_hold_data", rd_data_out, 32'hA5A5_0001);
    tick();
    rd_ready_in = 1'b1;
    tick();
    rd_ready_in = 1'b0;
    @(negedge clk_in);
    check("w1_popped_valid", rd_valid_out, 0);
    check("w1_popped_count", count_out, 0);

    // Streaming: 100 words, no bubbles once the first word appears
    sent = 0;
    recv = 0;
    rd_ready_in = 1'b1;
    for (int cyc = 0; cyc < 200 && recv < 100; cyc++) begin
      tick();
      wr_valid_in = (sent < 100);
      wr_data_in  = 32'h1000_0000 + sent;
      @(negedge clk_in);
      if (recv > 0) check("stream_no_bubble", rd_valid_out, 1);
      if (rd_valid_out) begin
        check("stream_data", rd_data_out, 32'h1000_0000 + recv);
        recv++;
      end
      if (wr_valid_in && wr_ready_out) sent++;
    end
    check("stream_all_received", recv, 100);
    wr_valid_in = 1'b0;
    rd_ready_in = 1'b0;

    // Fill to DEPTH+2, then drain in order across the address wrap
    do_reset();
    sent = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      wr_valid_in = 1'b1;
      wr_data_in  = 32'h2000_0000 + sent;
      @(negedge clk_in);
      if (wr_ready_out) begin
        if (sent == DEPTH) check("full_addr_wrap", sram_addr_a_out, 0);
        sent++;
      end
    end
    check("full_accepted", sent, DEPTH + 2);
    check("full_count", count_out, DEPTH + 2);
    check("full_wr_ready", wr_ready_out, 0);
    tick();
    wr_valid_in = 1'b0;
    rd_ready_in = 1'b1;
    @(negedge clk_in);
    check("full_pop_no_bypass", wr_ready_out, 0);
    check("full_refill_en_b", sram_en_b_out, 1);
    check("full_refill_addr_b", sram_addr_b_out, 2);
    check("drain_data", rd_data_out, 32'h2000_0000);
    recv = 1;
    tick();
    @(negedge clk_in);
    check("full_ready_back", wr_ready_out, 1);
    for (int cyc = 0; cyc < 60 && recv < DEPTH + 2; cyc++) begin
      if (rd_valid_out) begin
        check("drain_data", rd_data_out, 32'h2000_0000 + recv);
        recv++;
      end
      tick();
      @(negedge clk_in);
    end
    check("drain_all", recv, DEPTH + 2);
    check("drain_count", count_out, 0);

    // Random back-pressure against a queue scoreboard
    do_reset();
    held_v = 1'b0;
    held_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      wr_valid_in = ($urandom_range(0, 3) != 0);
      wr_data_in  = $urandom;
      rd_ready_in = (cyc < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      check("rand_count", count_out, sb.size());
      if (held_v) begin
        check("stall_valid", rd_valid_out, 1);
        check("stall_stable", rd_data_out, held_d);
      end
      if (wr_valid_in && wr_ready_out) sb.push_back(wr_data_in);
      if (rd_valid_out && rd_ready_in) begin
        if (sb.size() > 0) check("rand_data", rd_data_out, sb.pop_front());
        else check("rand_spurious", rd_valid_out, 0);
      end
      held_v = rd_valid_out && !rd_ready_in;
      held_d = rd_data_out;
    end
    wr_valid_in = 1'b0;
    rd_ready_in = 1'b1;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      tick();
      @(negedge clk_in);
      if (rd_valid_out && sb.size() > 0) check("rand_drain", rd_data_out, sb.pop_front());
    end
    tick();
    @(negedge clk_in);
    check("rand_final_count", count_out, 0);

    // Reset while a prefetch read is in flight
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      wr_valid_in = 1'b1;
      wr_data_in  = 32'h3000_0000 + i;
    end
    tick();
    wr_data_in  = 32'h3000_0005;
    rd_ready_in = 1'b1;
    @(negedge clk_in);
    check("mid_issue", sram_en_b_out, 1);
    check("mid_count_pre", count_out, 5);
    tick();
    wr_valid_in = 1'b0;
    rd_ready_in = 1'b0;
    rst_in      = 1'b1;
    @(negedge clk_in);
    check("mid_count_inflight", count_out, 5);
    check("mid_rst_wr_ready", wr_ready_out, 0);
    check("mid_rst_en_b", sram_en_b_out, 0);
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("mid_after_count", count_out, 0);
    check("mid_after_valid", rd_valid_out, 0);
    tick();
    @(negedge clk_in);
    check("mid_no_capture_valid", rd_valid_out, 0);
    check("mid_no_capture_count", count_out, 0);
    check("mid_no_capture_data", rd_data_out, 0);

`ifdef SRAM_FIFO_AFULL_EN
    // Almost-full flag with threshold 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      wr_valid_in = 1'b1;
      wr_data_in  = 32'h4000_0000 + i;
    end
    tick();
    wr_valid_in = 1'b0;
    @(negedge clk_in);
    check("afull_count8", count_out, 8);
    check("afull_not_yet", afull_out, 0);
    tick();
    @(negedge clk_in);
    check("afull_rise", afull_out, 1);
    tick();
    rd_ready_in = 1'b1;
    @(negedge clk_in);
    check("afull_at_pop", afull_out, 1);
    tick();
    rd_ready_in = 1'b0;
    @(negedge clk_in);
    check("afull_count7", count_out, 7);
    check("afull_lag", afull_out, 1);
    tick();
    @(negedge clk_in);
    check("afull_fall", afull_out, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
